// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master -- single-master I2C bit engine.
//
// Executes one bus primitive (START, STOP, READ_BYTE, WRITE_BYTE) per
// enable/complete handshake. No clock stretching and no arbitration.
// Every SCL period is four quarters of CLK_DIV clk_i cycles each.
//
// Optional feature macro: I2C_ACK_CHECK_EN
//   defined   -> ack_error_o reports a slave NACK at the end of WRITE_BYTE
//   undefined -> ack_error_o is tied low (timing is unchanged)
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset (releases the bus)
//   instruction_i   0=START, 1=STOP, 2=READ_BYTE, 3=WRITE_BYTE
//   enable_i        command request, held until complete_o is seen
//   byte_to_send_i  data for WRITE_BYTE
//   byte_received_o last byte read
//   complete_o      command finished while enable_i is still high
//   ack_error_o     slave NACK flag
//   scl_o           SCL level (push-pull)
//   sda_oe_o        1 = pull SDA low, 0 = release
//   sda_i           SDA pin readback
// ---------------------------------------------------------------------------
module i2c_master #(
    parameter int CLK_DIV = 17
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] instruction_i,
    input  logic       enable_i,
    input  logic [7:0] byte_to_send_i,
    output logic [7:0] byte_received_o,
    output logic       complete_o,
    output logic       ack_error_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] INS_START = 2'd0;
    localparam logic [1:0] INS_STOP  = 2'd1;
    localparam logic [1:0] INS_READ  = 2'd2;

    typedef enum logic [2:0] {IDLE, START, STOP, WRITE, READ, DONE} state_t;

    state_t           state;
    logic [1:0]       cmd;
    logic [7:0]       shreg;
    logic [DIV_W-1:0] div;
    logic [1:0]       q;
    logic [3:0]       bit_idx;

    logic div_wrap;
    logic last_quarter;
    logic sample_pt;
    logic last_bit;

    assign div_wrap     = (div == DIV_LAST);
    assign last_quarter = div_wrap && (q == 2'd3);
    // Last cycle of q1: SCL has been high for CLK_DIV-1 cycles by now.
    assign sample_pt    = div_wrap && (q == 2'd1);
    assign last_bit     = (bit_idx == 4'd8);

`ifdef I2C_ACK_CHECK_EN
    logic ack_bit;
`else
    assign ack_error_o = 1'b0;
`endif

    // Outputs are registered from the current quarter, so each quarter's
    // pin levels appear one cycle after the quarter begins; the extra cycle
    // on complete_o comes from registering it in DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            cmd             <= INS_START;
            shreg           <= 8'h00;
            div             <= '0;
            q               <= 2'd0;
            bit_idx         <= 4'd0;
            scl_o           <= 1'b1;
            sda_oe_o        <= 1'b0;
            complete_o      <= 1'b0;
            byte_received_o <= 8'h00;
`ifdef I2C_ACK_CHECK_EN
            ack_bit         <= 1'b0;
            ack_error_o     <= 1'b0;
`endif
        end else begin
            if (state == START || state == STOP || state == WRITE || state == READ) begin
                if (div_wrap) begin
                    div <= '0;
                    q   <= q + 2'd1;
                    if (q == 2'd3 && !last_bit)
                        bit_idx <= bit_idx + 4'd1;
                end else begin
                    div <= div + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    complete_o <= 1'b0;
                    if (enable_i) begin
                        cmd     <= instruction_i;
                        shreg   <= byte_to_send_i;
                        div     <= '0;
                        q       <= 2'd0;
                        bit_idx <= 4'd0;
`ifdef I2C_ACK_CHECK_EN
                        ack_error_o <= 1'b0;
`endif
                        case (instruction_i)
                            2'd0:    state <= START;
                            2'd1:    state <= STOP;
                            2'd2:    state <= READ;
                            default: state <= WRITE;
                        endcase
                    end
                end

                // q0 keeps SCL as it is, so a START from an idle bus does not
                // pulse SCL and a repeated START raises SCL before SDA falls.
                START: begin
                    case (q)
                        2'd0:    sda_oe_o <= 1'b0;
                        2'd1:    scl_o    <= 1'b1;
                        2'd2:    sda_oe_o <= 1'b1;
                        default: scl_o    <= 1'b0;
                    endcase
                    if (last_quarter)
                        state <= DONE;
                end

                STOP: begin
                    case (q)
                        2'd0: begin
                            sda_oe_o <= 1'b1;
                            scl_o    <= 1'b0;
                        end
                        2'd1:    scl_o    <= 1'b1;
                        2'd2:    sda_oe_o <= 1'b0;
                        default: ;
                    endcase
                    if (last_quarter)
                        state <= DONE;
                end

                WRITE: begin
                    scl_o    <= (q == 2'd1) || (q == 2'd2);
                    sda_oe_o <= last_bit ? 1'b0 : ~shreg[7];
`ifdef I2C_ACK_CHECK_EN
                    if (sample_pt && last_bit)
                        ack_bit <= sda_i;
`endif
                    if (last_quarter) begin
                        shreg <= {shreg[6:0], 1'b0};
                        if (last_bit) begin
                            state <= DONE;
`ifdef I2C_ACK_CHECK_EN
                            ack_error_o <= ack_bit;
`endif
                        end
                    end
                end

                READ: begin
                    scl_o    <= (q == 2'd1) || (q == 2'd2);
                    // Master ACK on the ninth bit, release otherwise.
                    sda_oe_o <= last_bit;
                    if (sample_pt && !last_bit)
                        shreg <= {shreg[6:0], sda_i};
                    if (last_quarter && last_bit) begin
                        state           <= DONE;
                        byte_received_o <= shreg;
                    end
                end

                DONE: begin
                    // Only a START leaves SDA held low for the next primitive.
                    sda_oe_o <= (cmd == INS_START);
                    if (enable_i) begin
                        complete_o <= 1'b1;
                    end else begin
                        complete_o <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
module tb_i2c_master;

    localparam int CLK_DIV = 4;
    localparam logic [1:0] INS_START = 2'd0;
    localparam logic [1:0] INS_STOP  = 2'd1;
    localparam logic [1:0] INS_READ  = 2'd2;
    localparam logic [1:0] INS_WRITE = 2'd3;

`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] instruction = 2'd0;
    logic       enable = 1'b0;
    logic [7:0] byte_to_send = 8'h00;
    logic [7:0] byte_received;
    logic       complete;
    logic       ack_error;
    logic       scl;
    logic       sda_oe;
    logic       sda_line;
    logic       slave_low = 1'b0;

    // Open-drain bus: either side may pull SDA low.
    assign sda_line = ~(sda_oe | slave_low);

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instruction_i  (instruction),
        .enable_i       (enable),
        .byte_to_send_i (byte_to_send),
        .byte_received_o(byte_received),
        .complete_o     (complete),
        .ack_error_o    (ack_error),
        .scl_o          (scl),
        .sda_oe_o       (sda_oe),
        .sda_i          (sda_line)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bus monitor and slave, evaluated on the falling clock edge.
    int unsigned nfall = 0, nrise = 0, n_start = 0, n_stop = 0, ack_hole = 0;
    logic        obs [0:1023];
    logic        scl_prev = 1'b1, sda_prev = 1'b1;
    int unsigned fall_base = 0, rise_base = 0;
    logic        slave_active = 1'b0;
    logic        read_watch = 1'b0;
    logic [8:0]  slave_vec = 9'h1FF;   // [8] is the first bit on the wire

    always @(negedge clk) begin
        int unsigned k;
        if (scl_prev && !scl) nfall++;
        if (!scl_prev && scl) begin
            obs[nrise % 1024] = sda_line;
            nrise++;
        end
        if (scl_prev && scl && (sda_prev != sda_line)) begin
            if (!sda_line) n_start++;
            else           n_stop++;
        end
        if (read_watch && scl && (nrise - rise_base) == 9 && !sda_oe) ack_hole++;
        scl_prev = scl;
        sda_prev = sda_line;
        k = nfall - fall_base;
        slave_low = slave_active && (k < 9) && !slave_vec[8 - k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] model_byte = 8'h00;

    task automatic run_cmd(input string tag, input logic [1:0] ins, input logic [7:0] data,
                           input logic [7:0] sbyte, input logic sack, input int hold,
                           input int exp_lat, input logic [8:0] exp_bits,
                           input logic [7:0] exp_byte, input logic exp_ack);
        int          lat;
        int          drops;
        int unsigned s0, p0, r0, h0;
        logic [8:0]  bits;
        @(posedge clk); #1;
        s0 = n_start; p0 = n_stop; r0 = nrise; h0 = ack_hole;
        fall_base    = nfall;
        rise_base    = nrise;
        slave_vec    = (ins == INS_READ) ? {sbyte, 1'b1} : {8'hFF, ~sack};
        slave_active = (ins == INS_READ) || (ins == INS_WRITE);
        read_watch   = (ins == INS_READ);
        instruction  = ins;
        byte_to_send = data;
        enable       = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!complete && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " byte_received"}, byte_received, exp_byte);
        chk({tag, " ack_error"}, ack_error, exp_ack);
        if (ins == INS_READ || ins == INS_WRITE) begin
            for (int k = 0; k < 9; k++) bits[8-k] = obs[(r0 + k) % 1024];
            chk({tag, " scl rises"}, nrise - r0, 9);
            chk({tag, " sda bits"}, bits, exp_bits);
            chk({tag, " start/stop events"}, (n_start - s0) + (n_stop - p0), 0);
            chk({tag, " scl low"}, scl, 1'b0);
            if (ins == INS_READ) chk({tag, " master ack gap"}, ack_hole - h0, 0);
        end else if (ins == INS_START) begin
            chk({tag, " start events"}, n_start - s0, 1);
            chk({tag, " stop events"}, n_stop - p0, 0);
            chk({tag, " sda held"}, {scl, sda_oe}, 2'b01);
        end else begin
            chk({tag, " stop events"}, n_stop - p0, 1);
            chk({tag, " start events"}, n_start - s0, 0);
            chk({tag, " bus idle"}, {scl, sda_oe}, 2'b10);
        end
        if (hold > 0) begin
            drops = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!complete) drops++;
            end
            chk({tag, " complete held"}, drops, 0);
            chk({tag, " no retrigger"}, (n_start - s0) + (n_stop - p0) + (nrise - r0 > 9 ? 1 : 0),
                (ins == INS_START || ins == INS_STOP) ? 1 : 0);
        end
        enable       = 1'b0;
        slave_active = 1'b0;
        read_watch   = 1'b0;
        @(posedge clk); #1;
        chk({tag, " complete drop"}, complete, 1'b0);
    endtask

    // Reference model: expectations straight from the protocol rules.
    task automatic run_rand(input string tag, input logic [1:0] ins);
        logic [7:0] data, sbyte;
        logic       sack;
        int         exp_lat;
        logic [8:0] exp_bits;
        logic       exp_ack;
        data  = 8'($urandom);
        sbyte = 8'($urandom);
        sack  = 1'($urandom_range(0, 1));
        exp_lat  = (ins == INS_READ || ins == INS_WRITE) ? 36 * CLK_DIV + 1 : 4 * CLK_DIV + 1;
        exp_bits = 9'h000;
        if (ins == INS_READ) begin
            model_byte = sbyte;
            exp_bits   = {sbyte, 1'b0};
        end else if (ins == INS_WRITE) begin
            exp_bits = {data, ~sack};
        end
        exp_ack = ACK_CHK && (ins == INS_WRITE) && !sack;
        run_cmd(tag, ins, data, sbyte, sack, 0, exp_lat, exp_bits, model_byte, exp_ack);
    endtask

    typedef struct {
        logic [1:0] ins;
        logic [7:0] data;
        logic [7:0] sbyte;
        logic       sack;
        int         hold;
        int         exp_lat;
        logic [8:0] exp_bits;
        logic [7:0] exp_byte;
        logic       exp_ack;
    } vec_t;

    vec_t tbl [0:10];

    initial begin
        int drops;
        int r;

        tbl[0]  = '{INS_START, 8'h00, 8'h00, 1'b1, 10, 17,  9'h000, 8'h00, 1'b0};
        tbl[1]  = '{INS_WRITE, 8'h90, 8'h00, 1'b1, 0,  145, 9'h120, 8'h00, 1'b0};
        tbl[2]  = '{INS_WRITE, 8'h90, 8'h00, 1'b0, 0,  145, 9'h121, 8'h00, ACK_CHK};
        tbl[3]  = '{INS_START, 8'h00, 8'h00, 1'b1, 0,  17,  9'h000, 8'h00, 1'b0};
        tbl[4]  = '{INS_WRITE, 8'h91, 8'h00, 1'b1, 0,  145, 9'h122, 8'h00, 1'b0};
        tbl[5]  = '{INS_READ,  8'h00, 8'h12, 1'b1, 0,  145, 9'h024, 8'h12, 1'b0};
        tbl[6]  = '{INS_READ,  8'h00, 8'h34, 1'b1, 0,  145, 9'h068, 8'h34, 1'b0};
        tbl[7]  = '{INS_STOP,  8'h00, 8'h00, 1'b1, 0,  17,  9'h000, 8'h34, 1'b0};
        tbl[8]  = '{INS_START, 8'h00, 8'h00, 1'b1, 0,  17,  9'h000, 8'h34, 1'b0};
        tbl[9]  = '{INS_READ,  8'h00, 8'hA5, 1'b1, 0,  145, 9'h14A, 8'hA5, 1'b0};
        tbl[10] = '{INS_STOP,  8'h00, 8'h00, 1'b1, 0,  17,  9'h000, 8'hA5, 1'b0};

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {scl, sda_oe, complete, ack_error, byte_received}, {4'b1000, 8'h00});
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i <= 10; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].ins, tbl[i].data, tbl[i].sbyte, tbl[i].sack,
                    tbl[i].hold, tbl[i].exp_lat, tbl[i].exp_bits, tbl[i].exp_byte, tbl[i].exp_ack);
            model_byte = tbl[i].exp_byte;
        end

        // Randomized sessions
        for (int s = 0; s < 3; s++) begin
            run_rand($sformatf("rnd%0d start", s), INS_START);
            for (int j = 0; j < 4; j++) begin
                r = $urandom_range(0, 9);
                if (r == 0)     run_rand($sformatf("rnd%0d.%0d rstart", s, j), INS_START);
                else if (r < 5) run_rand($sformatf("rnd%0d.%0d read", s, j), INS_READ);
                else            run_rand($sformatf("rnd%0d.%0d write", s, j), INS_WRITE);
            end
            run_rand($sformatf("rnd%0d stop", s), INS_STOP);
        end

        // enable_i dropped mid-WRITE: command finishes silently, then IDLE
        run_rand("drop start", INS_START);
        @(posedge clk); #1;
        fall_base = nfall; rise_base = nrise;
        slave_vec = 9'h1FE; slave_active = 1'b1;
        instruction = INS_WRITE; byte_to_send = 8'h5A; enable = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        drops = 0;
        for (int i = 0; i < 36 * CLK_DIV + 10; i++) begin
            @(posedge clk); #1;
            if (complete) drops++;
        end
        slave_active = 1'b0;
        chk("drop no complete", drops, 0);
        run_rand("drop after start", INS_START);
        run_rand("drop after stop", INS_STOP);

        // Asynchronous reset mid-WRITE
        run_rand("rst start", INS_START);
        @(posedge clk); #1;
        fall_base = nfall; rise_base = nrise;
        slave_vec = 9'h1FE; slave_active = 1'b1;
        instruction = INS_WRITE; byte_to_send = 8'h00; enable = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #2;
        chk("pre-reset sda driven", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        chk("async reset outputs", {scl, sda_oe, complete, ack_error, byte_received}, {4'b1000, 8'h00});
        enable = 1'b0;
        slave_active = 1'b0;
        model_byte = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_rand("post-reset start", INS_START);
        run_rand("post-reset write", INS_WRITE);
        run_rand("post-reset stop", INS_STOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C bit engine that executes one primitive (START, STOP, READ_BYTE, WRITE_BYTE) per enable/complete handshake.
- Sits directly downstream of the ADS1115 sequencer (adc), which drives instruction_i, enable_i and byte_to_send_i and consumes byte_received_o and complete_o.
- Drives the physical SCL/SDA pins on the Tang Nano 20K top level; no clock stretching, no arbitration.

Parameters:
- CLK_DIV, 17, clk_i cycles per SCL quarter-period (SCL period = 4*CLK_DIV; 27 MHz/68 ≈ 397 kHz). Legal range >= 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- instruction_i  input  2  0=START, 1=STOP, 2=READ_BYTE, 3=WRITE_BYTE
- enable_i  input  1  command request, held high until complete_o is seen
- byte_to_send_i  input  8  data for WRITE_BYTE
- byte_received_o  output  8  last byte read
- complete_o  output  1  high while the command is finished and enable_i is still high
- ack_error_o  output  1  slave NACK flag (see Optional Feature)
- scl_o  output  1  SCL level, push-pull
- sda_oe_o  output  1  1 = pull SDA low, 0 = release (top: SDA = sda_oe_o ? 0 : Z)
- sda_i  input  1  SDA pin readback

Behaviour:
- Reset values: scl_o=1, sda_oe_o=0, complete_o=0, byte_received_o=0, ack_error_o=0, state IDLE. Reset applies immediately mid-operation; the bus is released on assertion.
- States: IDLE, START, STOP, WRITE, READ, DONE.
- Counters: divider 0..CLK_DIV-1; quarter index q 0..3 advances on divider wrap; bit index 0..8 advances on q=3 wrap.
- IDLE: on enable_i=1, latch instruction_i and byte_to_send_i (shift register), clear divider/q/bit, go to the command state. Inputs are ignored while busy.
- START (4 quarters): q0 SDA released, SCL=0 (SCL stays high if already high); q1 SCL=1; q2 SDA low; q3 SCL=0. This sequence supports repeated START.
- STOP (4 quarters): q0 SDA low, SCL=0; q1 SCL=1; q2 SDA released; q3 hold. The bus ends idle (SCL=1, SDA released).
- WRITE (9 bits x 4 quarters):
  - Bits 0-7 MSB first: q0 SCL=0 and SDA set (oe = ~bit); q1/q2 SCL=1; q3 SCL=0.
  - Bit 8 (ACK): SDA released; sda_i sampled on the last cycle of q1.
- READ (9 bits):
  - Bits 0-7: SDA released; sda_i sampled on the last cycle of q1 and shifted in MSB first.
  - Bit 8: master ACK (sda_oe_o=1 for all four quarters).
  - byte_received_o is updated on entry to DONE and holds until the next READ completes.
- Latency from the accepting edge to complete_o=1: START/STOP 4*CLK_DIV+1 cycles; READ/WRITE 36*CLK_DIV+1 cycles.
- DONE: complete_o=1; SCL low after byte ops, SDA released except after START (held low). While enable_i=1, stay in DONE with no re-trigger. When enable_i=0, go to IDLE and drop complete_o the next cycle.
- complete_o is 0 in IDLE and all busy states, so the requester sees complete low before high.
- enable_i dropped mid-command: the command finishes; DONE is held for one cycle, then IDLE.

Optional Feature:
- Macro I2C_ACK_CHECK_EN.
- Defined: ack_error_o is set at the end of WRITE if the sampled ACK bit was 1, and cleared when the next command is accepted.
- Undefined: ack_error_o is tied 0 and the ACK bit is not registered; all timing is identical.

Test Plan:
- Reset, CLK_DIV=4: hold rst_i -> scl_o=1, sda_oe_o=0, complete_o=0, byte_received_o=0x00; assert rst_i mid-WRITE -> same values within 1 cycle, asynchronously.
- START from idle bus -> SDA falls while SCL=1; complete_o rises exactly 17 cycles after the accepting edge; enable_i stays high 10 more cycles -> no second START; drop enable_i -> complete_o=0 next cycle.
- WRITE 0x90 with slave model ACKing -> SDA at the 9 SCL rising edges reads 1,0,0,1,0,0,0,0,0; complete_o after 145 cycles; ack_error_o=0. Repeat with slave NACK -> ack_error_o=1 (macro on) or 0 (macro off).
- READ with slave driving 0xA5 -> byte_received_o=0xA5; sda_oe_o=1 throughout the 9th SCL high period.
- ADC-style sequence START, WRITE 0x91, READ, READ, STOP (slave returns 0x12, 0x34) -> bytes 0x12 then 0x34 captured; STOP shows SDA rising while SCL=1; final state scl_o=1, sda_oe_o=0.
- Repeated START after WRITE (SCL low) -> SCL rises before SDA falls; no SDA edge occurs while SCL=1 except the START fall.
